alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_multicycle.sv | 154 +++++++++++++++
 tb/tb_alu_multicycle.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ALU with single-cycle logic/arith ops and iterative mul/divu
// Results are registered on entry to FIN and held until the next FIN entry.
module alu_multicycle #(
  parameter int WIDTH  = 32,
  parameter int OPRN_W = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [OPRN_W-1:0] OPRN,
  input  logic [WIDTH-1:0]  OP1,
  input  logic [WIDTH-1:0]  OP2,
  output logic [WIDTH-1:0]  OUT,
  output logic [WIDTH-1:0]  HI,
  output logic              ZERO,
  output logic              BUSY,
  output logic              DONE,
  output logic              DIV0
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [OPRN_W-1:0] OPC_ADD  = OPRN_W'(1);
  localparam logic [OPRN_W-1:0] OPC_SUB  = OPRN_W'(2);
  localparam logic [OPRN_W-1:0] OPC_MUL  = OPRN_W'(3);
  localparam logic [OPRN_W-1:0] OPC_SHL  = OPRN_W'(4);
  localparam logic [OPRN_W-1:0] OPC_SHR  = OPRN_W'(5);
  localparam logic [OPRN_W-1:0] OPC_AND  = OPRN_W'(6);
  localparam logic [OPRN_W-1:0] OPC_OR   = OPRN_W'(7);
  localparam logic [OPRN_W-1:0] OPC_NOR  = OPRN_W'(8);
  localparam logic [OPRN_W-1:0] OPC_SLT  = OPRN_W'(9);
  localparam logic [OPRN_W-1:0] OPC_DIVU = OPRN_W'(10);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] b_r;
  logic [CW-1:0]    cnt;
  logic             is_mul;

  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;
  logic             res_div0;
  logic             iter_req;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;

  // divu by zero is not iterative: it takes the single-cycle path below
  assign iter_req = (OPRN == OPC_MUL) || ((OPRN == OPC_DIVU) && (OP2 != '0));

  always_comb begin
    res_lo   = '0;
    res_hi   = '0;
    res_div0 = 1'b0;
    case (OPRN)
      OPC_ADD: res_lo = OP1 + OP2;
      OPC_SUB: res_lo = OP1 - OP2;
      OPC_SHL: res_lo = (OP2 >= WLIM) ? '0 : (OP1 << OP2[SW-1:0]);
      OPC_SHR: res_lo = (OP2 >= WLIM) ? '0 : (OP1 >> OP2[SW-1:0]);
      OPC_AND: res_lo = OP1 & OP2;
      OPC_OR:  res_lo = OP1 | OP2;
      OPC_NOR: res_lo = ~(OP1 | OP2);
      OPC_SLT: res_lo = {{(WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
      OPC_DIVU: begin
        res_lo   = '1;
        res_hi   = OP1;
        res_div0 = 1'b1;
      end
      default: res_lo = '0;
    endcase
  end

  // one iteration step; mul: {hi_r,lo_r} shift-add, divu: restoring with remainder in hi_r
  always_comb begin
    mul_sum   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
    div_shift = {hi_r, lo_r[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_r};
    if (is_mul) begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], lo_r[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      hi_nx = div_diff[WIDTH-1:0];
      lo_nx = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx = div_shift[WIDTH-1:0];
      lo_nx = {lo_r[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= IDLE;
      OUT    <= '0;
      HI     <= '0;
      ZERO   <= 1'b1;
      DIV0   <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      b_r    <= '0;
      cnt    <= '0;
      is_mul <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (START && iter_req) begin
            state  <= RUN;
            BUSY   <= 1'b1;
            is_mul <= (OPRN == OPC_MUL);
            hi_r   <= '0;
            cnt    <= '0;
            b_r    <= (OPRN == OPC_MUL) ? OP1 : OP2;
            lo_r   <= (OPRN == OPC_MUL) ? OP2 : OP1;
          end else if (START) begin
            state <= FIN;
            DONE  <= 1'b1;
            OUT   <= res_lo;
            HI    <= res_hi;
            ZERO  <= (res_lo == '0);
            DIV0  <= res_div0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          hi_r <= hi_nx;
          lo_r <= lo_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIN;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            OUT   <= lo_nx;
            HI    <= hi_nx;
            ZERO  <= (lo_nx == '0);
            DIV0  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - directed self-checking bench for alu_multicycle
module tb_alu_multicycle;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [5:0]  OPRN;
  logic [31:0] OP1;
  logic [31:0] OP2;
  logic [31:0] OUT;
  logic [31:0] HI;
  logic        ZERO;
  logic        BUSY;
  logic        DONE;
  logic        DIV0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  alu_multicycle #(.WIDTH(32), .OPRN_W(6)) dut (
    .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .OP1(OP1), .OP2(OP2),
    .OUT(OUT), .HI(HI), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    OPRN = op; OP1 = a; OP2 = b; START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // lat counts cycles from the accepting edge to the cycle where DONE is seen
  task automatic wait_done(output int lat);
    lat = 1;
    while (!DONE && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; START = 1'b1; OPRN = 6'h01; OP1 = 32'd5; OP2 = 32'd6;
    step(); step();
    checks++; if (OUT !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=%h", OUT, 32'h0); end
    checks++; if (HI !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", HI, 32'h0); end
    checks++; if (ZERO !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", ZERO); end
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || DIV0 !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b done=%b div0=%b exp=000", BUSY, DONE, DIV0); end
    RST = 1'b1;
    step();
    START = 1'b0;
    checks++; if (DONE !== 1'b1 || OUT !== 32'd11) begin failures++; $display("FAIL first_accept got done=%b out=%h exp done=1 out=%h", DONE, OUT, 32'd11); end
    step();
  endtask

  task automatic test_add_sub();
    issue(6'h01, 32'hFFFF_FFFF, 32'h1);
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL add_wrap_flags got done=%b busy=%b exp done=1 busy=0", DONE, BUSY); end
    checks++; if (OUT !== 32'h0 || ZERO !== 1'b1 || HI !== 32'h0) begin failures++; $display("FAIL add_wrap got out=%h zero=%b hi=%h exp out=0 zero=1 hi=0", OUT, ZERO, HI); end
    issue(6'h02, 32'd3, 32'd5);
    checks++; if (OUT !== 32'hFFFF_FFFE || ZERO !== 1'b0) begin failures++; $display("FAIL sub_wrap got out=%h zero=%b exp out=fffffffe zero=0", OUT, ZERO); end
    step();
    checks++; if (DONE !== 1'b0 || OUT !== 32'hFFFF_FFFE) begin failures++; $display("FAIL hold_after_fin got done=%b out=%h exp done=0 out=fffffffe", DONE, OUT); end
  endtask

  task automatic test_logic_shift();
    vec_t v[$];
    v.push_back('{6'h06, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234});
    v.push_back('{6'h07, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F});
    v.push_back('{6'h08, 32'hF000_0000, 32'h0000_000F, 32'h0FFF_FFF0});
    v.push_back('{6'h09, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001});
    v.push_back('{6'h09, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000});
    v.push_back('{6'h09, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000});
    v.push_back('{6'h09, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001});
    v.push_back('{6'h04, 32'h0000_0001, 32'd32,        32'h0000_0000});
    v.push_back('{6'h05, 32'h8000_0000, 32'd31,        32'h0000_0001});
    v.push_back('{6'h04, 32'h0000_0001, 32'd31,        32'h8000_0000});
    v.push_back('{6'h04, 32'h0000_0003, 32'd4,         32'h0000_0030});
    v.push_back('{6'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
    v.push_back('{6'h05, 32'h8000_0000, 32'd0,         32'h8000_0000});
    v.push_back('{6'h0B, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000});
    v.push_back('{6'h3F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b);
      checks++;
      if (DONE !== 1'b1 || OUT !== v[i].y || HI !== 32'h0 || ZERO !== (v[i].y == 32'h0)) begin
        failures++;
        $display("FAIL vec%0d op=%h got done=%b out=%h hi=%h zero=%b exp done=1 out=%h hi=0 zero=%b",
                 i, v[i].op, DONE, OUT, HI, ZERO, v[i].y, (v[i].y == 32'h0));
      end
    end
    step();
  endtask

  task automatic test_mul();
    int busy_cnt = 0;
    int lat;
    bit done_seen = 0;
    bit hold_ok = 1;
    issue(6'h01, 32'd7, 32'd0);
    step();
    issue(6'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 100 && !done_seen; i++) begin
      if (DONE) done_seen = 1;
      else begin
        if (BUSY) busy_cnt++;
        if (OUT !== 32'd7 || HI !== 32'h0) hold_ok = 0;
        START = 1'b1; OPRN = 6'h01; OP1 = $urandom; OP2 = $urandom;
        step();
      end
    end
    START = 1'b0;
    checks++; if (!done_seen) begin failures++; $display("FAIL mul_done_timeout got=0 exp=1"); end
    checks++; if (busy_cnt != 32) begin failures++; $display("FAIL mul_busy_cycles got=%0d exp=32", busy_cnt); end
    checks++; if (HI !== 32'hFFFF_FFFE || OUT !== 32'h1 || ZERO !== 1'b0) begin failures++; $display("FAIL mul_max got hi=%h out=%h zero=%b exp hi=fffffffe out=00000001 zero=0", HI, OUT, ZERO); end
    checks++; if (!hold_ok) begin failures++; $display("FAIL mul_run_hold got=changed exp=held"); end
    step();
    checks++; if (DONE !== 1'b0 || BUSY !== 1'b0 || OUT !== 32'h1) begin failures++; $display("FAIL mul_no_restart got done=%b busy=%b out=%h exp 0 0 1", DONE, BUSY, OUT); end
    issue(6'h03, 32'd3, 32'd5);
    wait_done(lat);
    checks++; if (lat != 33 || OUT !== 32'd15 || HI !== 32'h0) begin failures++; $display("FAIL mul_small got lat=%0d out=%h hi=%h exp lat=33 out=0000000f hi=0", lat, OUT, HI); end
    step();
    issue(6'h03, 32'h0001_0000, 32'h0001_0000);
    wait_done(lat);
    checks++; if (HI !== 32'h1 || OUT !== 32'h0 || ZERO !== 1'b1) begin failures++; $display("FAIL mul_carry got hi=%h out=%h zero=%b exp hi=1 out=0 zero=1", HI, OUT, ZERO); end
    step();
  endtask

  task automatic test_div();
    int lat;
    issue(6'h0A, 32'd100, 32'd7);
    checks++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin failures++; $display("FAIL div_busy got busy=%b done=%b exp busy=1 done=0", BUSY, DONE); end
    wait_done(lat);
    checks++; if (DONE !== 1'b1 || lat != 33) begin failures++; $display("FAIL div_latency got done=%b lat=%0d exp done=1 lat=33", DONE, lat); end
    checks++; if (OUT !== 32'd14 || HI !== 32'd2 || DIV0 !== 1'b0) begin failures++; $display("FAIL div_100_7 got q=%0d r=%0d div0=%b exp q=14 r=2 div0=0", OUT, HI, DIV0); end
    step();
    issue(6'h0A, 32'd100, 32'd0);
    checks++; if (DONE !== 1'b1 || OUT !== 32'hFFFF_FFFF || HI !== 32'd100 || DIV0 !== 1'b1) begin failures++; $display("FAIL div0 got done=%b out=%h hi=%0d div0=%b exp done=1 out=ffffffff hi=100 div0=1", DONE, OUT, HI, DIV0); end
    step();
    checks++; if (DIV0 !== 1'b1 || DONE !== 1'b0) begin failures++; $display("FAIL div0_hold got div0=%b done=%b exp div0=1 done=0", DIV0, DONE); end
    issue(6'h01, 32'd1, 32'd1);
    checks++; if (DIV0 !== 1'b0 || OUT !== 32'd2) begin failures++; $display("FAIL div0_clear got div0=%b out=%h exp div0=0 out=2", DIV0, OUT); end
    step();
    issue(6'h0A, 32'd7, 32'd100);
    wait_done(lat);
    checks++; if (OUT !== 32'd0 || HI !== 32'd7 || ZERO !== 1'b1) begin failures++; $display("FAIL div_small got q=%h r=%h zero=%b exp q=0 r=7 zero=1", OUT, HI, ZERO); end
    step();
    issue(6'h0A, 32'hFFFF_FFFF, 32'd10);
    wait_done(lat);
    checks++; if (OUT !== 32'h1999_9999 || HI !== 32'd5) begin failures++; $display("FAIL div_max got q=%h r=%h exp q=19999999 r=5", OUT, HI); end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(6'h07, 32'h0, 32'h0);
    issue(6'h01, 32'd2, 32'd3);
    checks++; if (DONE !== 1'b1 || OUT !== 32'd5) begin failures++; $display("FAIL b2b_add got done=%b out=%h exp done=1 out=5", DONE, OUT); end
    issue(6'h03, 32'd4, 32'd5);
    wait_done(lat);
    checks++; if (lat != 33 || OUT !== 32'd20) begin failures++; $display("FAIL b2b_mul got lat=%0d out=%h exp lat=33 out=14", lat, OUT); end
    issue(6'h01, 32'd10, 32'd20);
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0 || OUT !== 32'd30) begin failures++; $display("FAIL b2b_after_mul got done=%b busy=%b out=%h exp 1 0 1e", DONE, BUSY, OUT); end
    step();
  endtask

  task automatic test_reset_abort();
    bit done_any = 0;
    issue(6'h01, 32'd5, 32'd5);
    step();
    issue(6'h03, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) step();
    RST = 1'b0;
    step();
    checks++; if (BUSY !== 1'b0 || DONE !== 1'b0 || OUT !== 32'h0 || HI !== 32'h0 || ZERO !== 1'b1) begin failures++; $display("FAIL abort_state got busy=%b done=%b out=%h hi=%h zero=%b exp 0 0 0 0 1", BUSY, DONE, OUT, HI, ZERO); end
    RST = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (DONE || BUSY) done_any = 1;
      step();
    end
    checks++; if (done_any) begin failures++; $display("FAIL abort_no_done got=activity exp=none"); end
    issue(6'h01, 32'd1, 32'd1);
    checks++; if (DONE !== 1'b1 || OUT !== 32'd2) begin failures++; $display("FAIL abort_then_add got done=%b out=%h exp done=1 out=2", DONE, OUT); end
    step();
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; OPRN = '0; OP1 = '0; OP2 = '0;
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_mul();
    test_div();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
